// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, byte-mask generation, lane alignment,
// split of word-crossing accesses into two word accesses, and load extension.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        mem_we,
  output logic [3:0]  mem_mask,
  output logic [31:0] mem_a,
  output logic [31:0] mem_di,
  input  logic [31:0] mem_do,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1, S_DONE} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;

  logic [3:0]  base_mask;
  logic [1:0]  off;
  logic [7:0]  m8;
  logic [63:0] d64;
  logic [31:0] word_a;
  logic [31:0] rd_raw;
  logic [31:0] rd_ext;

  assign off    = addr_q[1:0];
  assign m8     = {4'b0000, base_mask} << off;
  assign d64    = {32'b0, wdata_q} << {off, 3'b000};
  assign word_a = {addr_q[31:2], 2'b00};
  // hi_q is cleared on acceptance, so an unsplit access shifts in zeros.
  assign rd_raw = 32'({hi_q, lo_q} >> {off, 3'b000});
  assign dbg_state = state_q;

  always_comb begin
    base_mask = 4'b1111;
    case (size_q)
      2'b00:   base_mask = 4'b0001;
      2'b01:   base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
  end

  always_comb begin
    rd_ext = rd_raw;
    case (size_q)
      2'b00:   rd_ext = uns_q ? {24'b0, rd_raw[7:0]}  : {{24{rd_raw[7]}}, rd_raw[7:0]};
      2'b01:   rd_ext = uns_q ? {16'b0, rd_raw[15:0]} : {{16{rd_raw[15]}}, rd_raw[15:0]};
      default: rd_ext = rd_raw;
    endcase
  end

  // Valid/ready: a request transfers on a rising edge where req_valid && req_ready;
  // the response is a single-cycle rsp_valid pulse with no backpressure.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'b0;
    mem_we    = 1'b0;
    mem_mask  = 4'b0000;
    mem_a     = 32'b0;
    mem_di    = 32'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          lo_d    = 32'b0;
          hi_d    = 32'b0;
          state_d = S_ACC0;
        end
      end
      S_ACC0: begin
        mem_we   = we_q;
        mem_mask = m8[3:0];
        mem_a    = word_a;
        mem_di   = d64[31:0];
        if (!we_q) lo_d = mem_do;
        state_d  = (m8[7:4] != 4'b0000) ? S_ACC1 : S_DONE;
      end
      S_ACC1: begin
        mem_we   = we_q;
        mem_mask = m8[7:4];
        mem_a    = word_a + 32'd4;
        mem_di   = d64[63:32];
        if (!we_q) hi_d = mem_do;
        state_d  = S_DONE;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        rsp_rdata = we_q ? 32'b0 : rd_ext;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      lo_q    <= 32'b0;
      hi_q    <= 32'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a small word-organised memory model.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        mem_we;
  logic [3:0]  mem_mask;
  logic [31:0] mem_a;
  logic [31:0] mem_di;
  logic [31:0] mem_do;
  logic [1:0]  dbg_state;

  logic [31:0] mem [64];
  int checks;
  int failures;

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_we(mem_we), .mem_mask(mem_mask), .mem_a(mem_a), .mem_di(mem_di),
    .mem_do(mem_do), .dbg_state(dbg_state)
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_do = mem[mem_a[7:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      for (int l = 0; l < 4; l++)
        if (mem_mask[l]) mem[mem_a[7:2]][8*l +: 8] <= mem_di[8*l +: 8];
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        split;
    logic [31:0] a0;
    logic [3:0]  m0;
    logic [31:0] di0;
    logic [31:0] a1;
    logic [3:0]  m1;
    logic [31:0] di1;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic we, logic [1:0] size, logic uns, logic [31:0] addr,
                              logic [31:0] wdata, logic split, logic [31:0] a0, logic [3:0] m0,
                              logic [31:0] di0, logic [31:0] a1, logic [3:0] m1,
                              logic [31:0] di1, logic [31:0] rdata);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.split = split; v.a0 = a0; v.m0 = m0; v.di0 = di0;
    v.a1 = a1; v.m1 = m1; v.di1 = di1; v.rdata = rdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: called 1 time unit after a rising edge with the DUT in IDLE
  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    check({tag, ".idle_ready"}, {31'b0, req_ready}, 32'd1);
    req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check({tag, ".acc0_ready"}, {31'b0, req_ready}, 32'd0);
    check({tag, ".acc0_rsp"},   {31'b0, rsp_valid}, 32'd0);
    check({tag, ".acc0_we"},    {31'b0, mem_we}, {31'b0, v.we});
    check({tag, ".acc0_a"},     mem_a, v.a0);
    check({tag, ".acc0_mask"},  {28'b0, mem_mask}, {28'b0, v.m0});
    check({tag, ".acc0_di"},    mem_di, v.di0);
    tick();
    if (v.split) begin
      check({tag, ".acc1_ready"}, {31'b0, req_ready}, 32'd0);
      check({tag, ".acc1_we"},    {31'b0, mem_we}, {31'b0, v.we});
      check({tag, ".acc1_a"},     mem_a, v.a1);
      check({tag, ".acc1_mask"},  {28'b0, mem_mask}, {28'b0, v.m1});
      check({tag, ".acc1_di"},    mem_di, v.di1);
      tick();
    end
    check({tag, ".done_rsp"},   {31'b0, rsp_valid}, 32'd1);
    check({tag, ".done_ready"}, {31'b0, req_ready}, 32'd0);
    check({tag, ".done_we"},    {31'b0, mem_we}, 32'd0);
    check({tag, ".done_mask"},  {28'b0, mem_mask}, 32'd0);
    check({tag, ".rdata"},      rsp_rdata, v.rdata);
    tick();
    check({tag, ".post_rsp"},   {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    logic exp_ready [6];
    logic exp_rv    [6];
    checks = 0; failures = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'b0; req_wdata = 32'b0;

    //               we  sz     u     addr          wdata         sp  a0            m0       di0           a1            m1       di1           rdata
    vecs.push_back(mk(1, 2'b10, 1'b0, 32'h00000010, 32'hDEADBEEF, 0, 32'h00000010, 4'b1111, 32'hDEADBEEF, 32'h0,        4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(0, 2'b10, 1'b0, 32'h00000010, 32'h0,        0, 32'h00000010, 4'b1111, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hDEADBEEF));
    vecs.push_back(mk(1, 2'b00, 1'b0, 32'h00000013, 32'h000000A5, 0, 32'h00000010, 4'b1000, 32'hA5000000, 32'h0,        4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(0, 2'b00, 1'b0, 32'h00000013, 32'h0,        0, 32'h00000010, 4'b1000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hFFFFFFA5));
    vecs.push_back(mk(0, 2'b00, 1'b1, 32'h00000013, 32'h0,        0, 32'h00000010, 4'b1000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h000000A5));
    vecs.push_back(mk(1, 2'b01, 1'b0, 32'h00000012, 32'h00008001, 0, 32'h00000010, 4'b1100, 32'h80010000, 32'h0,        4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(0, 2'b01, 1'b0, 32'h00000012, 32'h0,        0, 32'h00000010, 4'b1100, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hFFFF8001));
    vecs.push_back(mk(0, 2'b00, 1'b0, 32'h00000010, 32'h0,        0, 32'h00000010, 4'b0001, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hFFFFFFEF));
    vecs.push_back(mk(0, 2'b00, 1'b1, 32'h00000011, 32'h0,        0, 32'h00000010, 4'b0010, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h000000BE));
    vecs.push_back(mk(0, 2'b11, 1'b0, 32'h00000010, 32'h0,        0, 32'h00000010, 4'b1111, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h8001BEEF));
    vecs.push_back(mk(1, 2'b10, 1'b0, 32'h00000007, 32'h11223344, 1, 32'h00000004, 4'b1000, 32'h44000000, 32'h00000008, 4'b0111, 32'h00112233, 32'h0));
    vecs.push_back(mk(0, 2'b10, 1'b0, 32'h00000007, 32'h0,        1, 32'h00000004, 4'b1000, 32'h0,        32'h00000008, 4'b0111, 32'h0,        32'h11223344));
    vecs.push_back(mk(1, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h0000009A, 0, 32'hFFFFFFFC, 4'b1000, 32'h9A000000, 32'h0,        4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(1, 2'b00, 1'b0, 32'h00000000, 32'h000000C3, 0, 32'h00000000, 4'b0001, 32'h000000C3, 32'h0,        4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0,        1, 32'hFFFFFFFC, 4'b1000, 32'h0,        32'h00000000, 4'b0001, 32'h0,        32'hFFFFC39A));
    vecs.push_back(mk(0, 2'b01, 1'b1, 32'hFFFFFFFF, 32'h0,        1, 32'hFFFFFFFC, 4'b1000, 32'h0,        32'h00000000, 4'b0001, 32'h0,        32'h0000C39A));
    vecs.push_back(mk(1, 2'b01, 1'b0, 32'h00000023, 32'h00005566, 1, 32'h00000020, 4'b1000, 32'h66000000, 32'h00000024, 4'b0001, 32'h00000055, 32'h0));
    vecs.push_back(mk(0, 2'b01, 1'b1, 32'h00000023, 32'h0,        1, 32'h00000020, 4'b1000, 32'h0,        32'h00000024, 4'b0001, 32'h0,        32'h00005566));

    // reset state
    reset = 1'b0;
    #12;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp",   {31'b0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_we",    {31'b0, mem_we}, 32'd0);
    check("rst_mask",  {28'b0, mem_mask}, 32'd0);
    check("rst_a",     mem_a, 32'd0);
    check("rst_di",    mem_di, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // back-to-back: req_valid held high, aligned load, 3-cycle cadence
    exp_ready = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_rv    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h00000010; req_wdata = 32'h0; req_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("b2b%0d.ready", k), {31'b0, req_ready}, {31'b0, exp_ready[k]});
      check($sformatf("b2b%0d.rsp", k),   {31'b0, rsp_valid}, {31'b0, exp_rv[k]});
      if (exp_rv[k]) check($sformatf("b2b%0d.rdata", k), rsp_rdata, 32'h8001BEEF);
      if (k == 5) req_valid = 1'b0;
      tick();
    end
    check("b2b.idle_ready", {31'b0, req_ready}, 32'd1);
    check("b2b.idle_rsp",   {31'b0, rsp_valid}, 32'd0);

    // reset during ACC1 of a split store
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h00000007; req_wdata = 32'hAABBCCDD; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("rst_mid.acc0_we", {31'b0, mem_we}, 32'd1);
    tick();
    check("rst_mid.acc1_we", {31'b0, mem_we}, 32'd1);
    check("rst_mid.acc1_a",  mem_a, 32'h00000008);
    reset = 1'b0;
    #1;
    check("rst_mid.we_drop",  {31'b0, mem_we}, 32'd0);
    check("rst_mid.mask",     {28'b0, mem_mask}, 32'd0);
    check("rst_mid.a",        mem_a, 32'd0);
    check("rst_mid.ready",    {31'b0, req_ready}, 32'd1);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_mid.post%0d_rsp", k),   {31'b0, rsp_valid}, 32'd0);
      check($sformatf("rst_mid.post%0d_ready", k), {31'b0, req_ready}, 32'd1);
      tick();
    end
    check("rst_mid.acc0_kept",   mem[1], 32'hDD000000);
    check("rst_mid.acc1_absent", mem[2], 32'h00112233);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
